// File: rtl/sgm_stream_pkg.sv
// Shared types and dimension defaults for the SGM streaming front end.
// The window extractor and cost-aggregation stages use the same constants.
package sgm_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_PIXEL_DEPTH  = 7;
    localparam int DEF_FRAME_WIDTH  = 640;
    localparam int DEF_FRAME_HEIGHT = 480;
    localparam int DEF_BLOCK_WIDTH  = 1;
    localparam int DEF_BLOCK_HEIGHT = 8;

    // A dimension of 1 still needs a one-bit counter.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/window_stream_sequencer_if.sv
// Raster pixel input stream. The sink is always ready: a pixel transfers
// on every cycle with in_valid high; in_sof is only meaningful with in_valid.
interface window_stream_sequencer_if #(
    parameter int PIXEL_DEPTH = sgm_stream_pkg::DEF_PIXEL_DEPTH
);
    logic                   in_valid;
    logic                   in_sof;
    logic [PIXEL_DEPTH-1:0] in_data;

    modport master (output in_valid, output in_sof, output in_data);
    modport slave  (input  in_valid, input  in_sof, input  in_data);
endinterface

// File: rtl/frame_pos_counter.sv
// Raster x/y position counter. x/y show the position of a pixel accepted this
// cycle; restart makes that position (0,0) so the counter follows from there.
module frame_pos_counter
    import sgm_stream_pkg::*;
#(
    parameter  int WIDTH  = DEF_FRAME_WIDTH,
    parameter  int HEIGHT = DEF_FRAME_HEIGHT,
    localparam int XW     = clog2_min1(WIDTH),
    localparam int YW     = clog2_min1(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          restart,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] LAST_X = XW'(WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    assign x    = restart ? '0 : x_q;
    assign y    = restart ? '0 : y_q;
    assign last = (x == LAST_X) && (y == LAST_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (inc) begin
            if (x == LAST_X) begin
                x_q <= '0;
                y_q <= (y == LAST_Y) ? '0 : y + 1'b1;
            end else begin
                x_q <= x + 1'b1;
                y_q <= y;
            end
        end else if (restart) begin
            x_q <= '0;
            y_q <= '0;
        end
    end

endmodule

// File: rtl/window_stream_sequencer.sv
// Feeds the line-buffer window extractor and produces a window-valid qualifier
// with coordinates aligned to the extractor's window output (two cycles after input).
module window_stream_sequencer
    import sgm_stream_pkg::*;
#(
    parameter  int PIXEL_DEPTH  = DEF_PIXEL_DEPTH,
    parameter  int FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter  int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter  int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
    parameter  int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
    localparam int XW           = clog2_min1(FRAME_WIDTH),
    localparam int YW           = clog2_min1(FRAME_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    window_stream_sequencer_if.slave bus,
    output logic                    sr_enable,
    output logic [PIXEL_DEPTH-1:0]  sr_data,
    output logic                    win_valid,
    output logic [XW-1:0]           win_x,
    output logic [YW-1:0]           win_y,
    output logic                    frame_done,
    output logic                    err_sof,
    output state_t                  fsm_state
);

    state_t        state_q, state_d;
    logic          accept, restart, sof_err, last, in_window;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;

    logic          s1_win, s1_done;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    assign restart   = bus.in_valid && bus.in_sof;
    assign fsm_state = state_q;

    frame_pos_counter #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .inc     (accept),
        .restart (restart),
        .x       (pos_x),
        .y       (pos_y),
        .last    (last)
    );

    // Rows from a frame before the latest (re)start sit at y < BLOCK_HEIGHT-1
    // of the new count, so they never qualify.
    assign in_window = (int'(pos_x) >= BLOCK_WIDTH - 1) &&
                       (int'(pos_y) >= BLOCK_HEIGHT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sof_err = 1'b0;
        case (state_q)
            IDLE: begin
                accept = restart;
            end
            ACTIVE: begin
                accept  = bus.in_valid;
                sof_err = restart;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) state_d = last ? IDLE : ACTIVE;
    end

    // Stage 1: shift into the extractor; window info travels alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_enable <= 1'b0;
            sr_data   <= '0;
            err_sof   <= 1'b0;
            s1_win    <= 1'b0;
            s1_done   <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
        end else begin
            sr_enable <= accept;
            err_sof   <= sof_err;
            if (accept) begin
                sr_data <= bus.in_data;
                s1_win  <= in_window;
                s1_done <= last;
                s1_x    <= pos_x;
                s1_y    <= pos_y;
            end
        end
    end

    // Stage 2: aligned with the window the extractor has just captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
        end else begin
            win_valid  <= sr_enable && s1_win;
            frame_done <= sr_enable && s1_done;
            if (sr_enable) begin
                win_x <= s1_x;
                win_y <= s1_y;
            end
        end
    end

endmodule

// File: tb/tb_window_stream_sequencer.sv
// Directed bench: 4x3 frames through a 2x2-window instance and a 1x1-window instance
// sharing one input stream; expected outputs are queued with their due cycle.
module tb_window_stream_sequencer;
    import sgm_stream_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_stream_sequencer_if #(.PIXEL_DEPTH(7)) bus ();

    logic       sr_enable, win_valid, frame_done, err_sof;
    logic [6:0] sr_data;
    logic [1:0] win_x, win_y;
    state_t     fsm_state;

    logic       sr_enable1, win_valid1, frame_done1, err_sof1;
    logic [6:0] sr_data1;
    logic [1:0] win_x1, win_y1;
    state_t     fsm_state1;

    window_stream_sequencer #(
        .PIXEL_DEPTH(7), .FRAME_WIDTH(4), .FRAME_HEIGHT(3),
        .BLOCK_WIDTH(2), .BLOCK_HEIGHT(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sr_enable(sr_enable), .sr_data(sr_data), .win_valid(win_valid),
        .win_x(win_x), .win_y(win_y), .frame_done(frame_done),
        .err_sof(err_sof), .fsm_state(fsm_state)
    );

    window_stream_sequencer #(
        .PIXEL_DEPTH(7), .FRAME_WIDTH(4), .FRAME_HEIGHT(3),
        .BLOCK_WIDTH(1), .BLOCK_HEIGHT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus),
        .sr_enable(sr_enable1), .sr_data(sr_data1), .win_valid(win_valid1),
        .win_x(win_x1), .win_y(win_y1), .frame_done(frame_done1),
        .err_sof(err_sof1), .fsm_state(fsm_state1)
    );

    // Entries: sr {cycle, data}; win {cycle, x, y, done, valid}; err {cycle}
    logic [22:0] sr_q[$];
    logic [21:0] w_q[$];
    logic [21:0] w1_q[$];
    logic [15:0] err_q[$];
    logic [15:0] err1_q[$];

    // Hand-computed 2x2 window hits in a 4x3 frame: pixel indices 5,6,7,9,10,11.
    logic [11:0] win_mask = 12'b1110_1110_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output at cycle %0d with nothing expected", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (sr_enable) begin
                if (sr_q.size() == 0) unexpected("sr_data");
                else check("sr_data", {9'd0, cyc[15:0], sr_data}, {9'd0, sr_q.pop_front()});
            end
            if (win_valid || frame_done) begin
                if (w_q.size() == 0) unexpected("window");
                else check("window", {10'd0, cyc[15:0], win_x, win_y, frame_done, win_valid},
                           {10'd0, w_q.pop_front()});
            end
            if (win_valid1 || frame_done1) begin
                if (w1_q.size() == 0) unexpected("window_1x1");
                else check("window_1x1", {10'd0, cyc[15:0], win_x1, win_y1, frame_done1, win_valid1},
                           {10'd0, w1_q.pop_front()});
            end
            if (err_sof) begin
                if (err_q.size() == 0) unexpected("err_sof");
                else check("err_sof", {16'd0, cyc[15:0]}, {16'd0, err_q.pop_front()});
            end
            if (err_sof1) begin
                if (err1_q.size() == 0) unexpected("err_sof_1x1");
                else check("err_sof_1x1", {16'd0, cyc[15:0]}, {16'd0, err1_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_px(input bit sof, input int d, input bit acc, input int ex, input int ey,
                            input bit ewin, input bit edone, input bit eerr);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = 7'(d);
        if (acc) begin
            sr_q.push_back({16'(cyc + 1), 7'(d)});
            w1_q.push_back({16'(cyc + 2), 2'(ex), 2'(ey), edone, 1'b1});
            if (ewin) w_q.push_back({16'(cyc + 2), 2'(ex), 2'(ey), edone, 1'b1});
        end
        if (eerr) begin
            err_q.push_back(16'(cyc + 1));
            err1_q.push_back(16'(cyc + 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
        end
    endtask

    // First n pixels of a frame, data base+i, gap idle cycles after each pixel.
    task automatic send_run(input int base, input int n, input int gap, input bit err_first);
        for (int i = 0; i < n; i++) begin
            drive_px(i == 0, base + i, 1'b1, i % 4, i / 4, win_mask[i], i == 11, err_first && (i == 0));
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sr_enable"},  {31'd0, sr_enable},  32'd0);
        check({tag, "_sr_data"},    {25'd0, sr_data},    32'd0);
        check({tag, "_win_valid"},  {31'd0, win_valid},  32'd0);
        check({tag, "_win_xy"},     {28'd0, win_x, win_y}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_err_sof"},    {31'd0, err_sof},    32'd0);
        check({tag, "_state"},      {31'd0, fsm_state},  {31'd0, IDLE});
        check({tag, "_win_1x1"},    {27'd0, win_valid1, win_x1, win_y1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        // Non-sof pixels after reset are discarded; then a continuous frame.
        drive_px(1'b0, 100, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive_px(1'b0, 101, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        send_run(1, 12, 0, 1'b0);
        idle(3);

        // Gapped input: valid pattern 1,0,0,1,...
        send_run(20, 12, 2, 1'b0);
        idle(3);

        // sof on pixel 7 aborts the frame and restarts at (0,0).
        send_run(40, 6, 0, 1'b0);
        send_run(50, 12, 0, 1'b1);
        idle(3);

        // Back-to-back frames, second sof right after the last pixel.
        send_run(70, 12, 0, 1'b0);
        send_run(90, 12, 0, 1'b0);
        idle(3);

        // Asynchronous reset mid-line after pixel 5.
        send_run(110, 5, 0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        #2;
        rst = 1'b1;
        sr_q.delete();
        w_q.delete();
        w1_q.delete();
        err_q.delete();
        err1_q.delete();
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_px(1'b0, 120, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive_px(1'b0, 121, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive_px(1'b0, 122, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        send_run(1, 12, 1, 1'b0);
        idle(6);

        check("sr_q_drained",   sr_q.size(),   32'd0);
        check("w_q_drained",    w_q.size(),    32'd0);
        check("w1_q_drained",   w1_q.size(),   32'd0);
        check("err_q_drained",  err_q.size() + err1_q.size(), 32'd0);
        check("final_state",    {31'd0, fsm_state}, {31'd0, IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
